fifo_drain_ctrl: RTL and testbench

- Single-clock read-side controller that drains a burst of `burst_len` words from a FIFO's read port and presents them on a valid/ready stream.
- Sits at the output of our FIFO blocks, e.g. after the last stage of a cascaded FIFO chain.
- Owns the FIFO read enable, absorbs the FIFO's 1-cycle read latency in a 4-entry skid buffer, and sustains one word per cycle when the consumer never stalls.

---
 rtl/fifo_drain_ctrl_if.sv | 31 +++
 rtl/fifo_drain_ctrl.sv | 130 +++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_ctrl_if.sv
// Read-port and output-stream bundle for the FIFO drain controller.
// master: the drain controller (drives FIFO read enable and the output stream).
// slave:  the surroundings (FIFO read port plus downstream consumer).
interface fifo_drain_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains a burst of words from a FIFO read port into a 4-entry skid buffer
// and presents them on a valid/ready stream, one word per cycle when unstalled.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_DRAIN | issuing FIFO reads under the credit rule until len issued
// S_FLUSH | no more reads; waiting for in-flight and buffered words to leave
// S_DONE  | one-cycle completion pulse, then back to idle
module fifo_drain_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_burst_len,
  fifo_drain_ctrl_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_words_read
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_words_read;
  logic [2:0]       r_occ;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic             r_inflight;
  logic [WIDTH-1:0] r_mem [4];

  logic             w_credit_ok;
  logic             w_rd_en;
  logic             w_push;
  logic             w_pop;
  logic             w_last_rd;
  logic             w_flush_done;
  logic [LEN_W-1:0] w_issued_nxt;

  // A read in flight already owns a buffer slot, so credit counts it with occ.
  assign w_credit_ok  = (r_occ + {2'b00, r_inflight}) < 3'd4;
  assign w_rd_en      = (r_state == S_DRAIN) && !bus.fifo_empty &&
                        (r_issued < r_len) && w_credit_ok;
  assign w_push       = r_inflight;
  assign w_pop        = bus.m_valid && bus.m_ready;
  assign w_issued_nxt = r_issued + 1'b1;
  assign w_last_rd    = w_rd_en && (w_issued_nxt == r_len);
  // Counting the pop in this cycle lets done follow the last accept directly.
  assign w_flush_done = !r_inflight &&
                        ((r_occ == 3'd0) || ((r_occ == 3'd1) && w_pop));

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_occ != 3'd0);
  assign bus.m_data     = r_mem[r_rd_ptr];
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_words_read   = r_words_read;

  // Burst sequencing: state, latched length, issued-read count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_issued <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len    <= i_burst_len;
            r_issued <= '0;
            r_state  <= (i_burst_len == '0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_rd_en) r_issued <= w_issued_nxt;
          if (w_last_rd) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_flush_done) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accepted-word counter; cleared on an accepted start, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words_read <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_words_read <= '0;
    end else if (w_pop) begin
      r_words_read <= r_words_read + 1'b1;
    end
  end

  // Skid buffer: capture read data one cycle after the read, pop on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.fifo_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // The credit rule must keep the buffer from ever holding more than 4 words.
  a_occ_bound: assert property (@(posedge clk) disable iff (rst) r_occ <= 3'd4);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: FIFO model, stream monitor and
// scenario tasks; delivered words must equal the FIFO contents in push order.
module tb_fifo_drain_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [LEN_W-1:0] i_burst_len = '0;
  logic             o_busy;
  logic             o_done;
  logic [LEN_W-1:0] o_words_read;

  fifo_drain_ctrl_if #(.WIDTH(WIDTH)) u_if ();

  fifo_drain_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_burst_len  (i_burst_len),
    .bus          (u_if),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_words_read (o_words_read)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  bit ready_rand = 1'b0;

  // FIFO model: array with push/pop indices, 1-cycle read latency.
  logic [WIDTH-1:0] fifo_mem [1024];
  int wr_idx = 0;
  int rd_idx = 0;
  assign u_if.fifo_empty = (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (u_if.fifo_rd_en) begin
      u_if.fifo_data <= fifo_mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor, sampled mid-cycle.
  logic [WIDTH-1:0] got_q [$];
  int               acc_cyc_q [$];
  int               rd_cnt = 0;
  int               done_cnt = 0;
  int               done_cyc = 0;
  int               hs_err = 0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!u_if.m_valid || (u_if.m_data !== prev_data))) hs_err++;
      prev_stall = u_if.m_valid && !u_if.m_ready;
      prev_data  = u_if.m_data;
      if (u_if.m_valid && u_if.m_ready) begin
        got_q.push_back(u_if.m_data);
        acc_cyc_q.push_back(cyc);
      end
      if (u_if.fifo_rd_en) rd_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) u_if.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    fifo_mem[wr_idx] = d;
    wr_idx++;
  endtask

  task automatic pulse_start(input int len, output int c0);
    i_start     = 1'b1;
    i_burst_len = LEN_W'(len);
    c0          = cyc;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt > db) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.m_ready = 1'b0;
    repeat (2) tick();
    vec_cnt++; if (u_if.fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_en got=%b exp=0", u_if.fifo_rd_en); end
    vec_cnt++; if (u_if.m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid got=%b exp=0", u_if.m_valid); end
    vec_cnt++; if (u_if.m_data !== 8'h00) begin err_cnt++; $display("FAIL reset_m_data got=%h exp=00", u_if.m_data); end
    vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    vec_cnt++; if (o_done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got=%b exp=0", o_done); end
    vec_cnt++; if (o_words_read !== 8'd0) begin err_cnt++; $display("FAIL reset_words_read got=%0d exp=0", o_words_read); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unstalled();
    int base, rb, db, c0;
    for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
    u_if.m_ready = 1'b1;
    base = got_q.size(); rb = rd_cnt; db = done_cnt;
    pulse_start(5, c0);
    repeat (11) tick();
    vec_cnt++; if (got_q.size() - base != 5) begin err_cnt++; $display("FAIL unstalled_count got=%0d exp=5", got_q.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() > base + i) begin
        vec_cnt++; if (got_q[base+i] !== 8'h11 + 8'(i)) begin err_cnt++; $display("FAIL unstalled_word%0d got=%h exp=%h", i, got_q[base+i], 8'h11 + 8'(i)); end
        vec_cnt++; if (acc_cyc_q[base+i] - c0 != 3 + i) begin err_cnt++; $display("FAIL unstalled_cycle%0d got=%0d exp=%0d", i, acc_cyc_q[base+i] - c0, 3 + i); end
      end
    end
    vec_cnt++; if (done_cnt - db != 1) begin err_cnt++; $display("FAIL unstalled_done_pulses got=%0d exp=1", done_cnt - db); end
    vec_cnt++; if (done_cyc - c0 != 8) begin err_cnt++; $display("FAIL unstalled_done_cycle got=%0d exp=8", done_cyc - c0); end
    vec_cnt++; if (o_words_read !== 8'd5) begin err_cnt++; $display("FAIL unstalled_words_read got=%0d exp=5", o_words_read); end
    vec_cnt++; if (rd_cnt - rb != 5) begin err_cnt++; $display("FAIL unstalled_reads got=%0d exp=5", rd_cnt - rb); end
  endtask

  task automatic test_backpressure();
    int base, rb, db, hb, c0, e0;
    bit ok;
    e0 = rd_idx;
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    u_if.m_ready = 1'b0;
    base = got_q.size(); rb = rd_cnt; db = done_cnt; hb = hs_err;
    pulse_start(8, c0);
    repeat (9) tick();
    vec_cnt++; if (rd_cnt - rb != 4) begin err_cnt++; $display("FAIL bp_reads_stalled got=%0d exp=4", rd_cnt - rb); end
    vec_cnt++; if (u_if.m_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid_held got=%b exp=1", u_if.m_valid); end
    vec_cnt++; if (u_if.m_data !== fifo_mem[e0]) begin err_cnt++; $display("FAIL bp_head_data got=%h exp=%h", u_if.m_data, fifo_mem[e0]); end
    u_if.m_ready = 1'b1;
    wait_done(db, 40, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    vec_cnt++; if (got_q.size() - base != 8) begin err_cnt++; $display("FAIL bp_count got=%0d exp=8", got_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (got_q.size() > base + i) begin
        vec_cnt++; if (got_q[base+i] !== fifo_mem[e0+i]) begin err_cnt++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[base+i], fifo_mem[e0+i]); end
      end
    end
    vec_cnt++; if (rd_cnt - rb != 8) begin err_cnt++; $display("FAIL bp_reads_total got=%0d exp=8", rd_cnt - rb); end
    vec_cnt++; if (o_words_read !== 8'd8) begin err_cnt++; $display("FAIL bp_words_read got=%0d exp=8", o_words_read); end
    vec_cnt++; if (hs_err != hb) begin err_cnt++; $display("FAIL bp_handshake got=%0d exp=%0d", hs_err, hb); end
    tick();
  endtask

  task automatic test_underrun();
    int base, db, c0, e0;
    bit ok;
    e0 = rd_idx;
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    u_if.m_ready = 1'b1;
    base = got_q.size(); db = done_cnt;
    pulse_start(6, c0);
    repeat (10) tick();
    vec_cnt++; if (got_q.size() - base != 3) begin err_cnt++; $display("FAIL underrun_partial got=%0d exp=3", got_q.size() - base); end
    vec_cnt++; if (o_busy !== 1'b1) begin err_cnt++; $display("FAIL underrun_busy got=%b exp=1", o_busy); end
    vec_cnt++; if (u_if.fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL underrun_rd_en got=%b exp=0", u_if.fifo_rd_en); end
    vec_cnt++; if (done_cnt != db) begin err_cnt++; $display("FAIL underrun_early_done got=%0d exp=%0d", done_cnt, db); end
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    wait_done(db, 30, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL underrun_done_timeout got=0 exp=1"); end
    repeat (4) tick();
    vec_cnt++; if (done_cnt - db != 1) begin err_cnt++; $display("FAIL underrun_done_pulses got=%0d exp=1", done_cnt - db); end
    vec_cnt++; if (got_q.size() - base != 6) begin err_cnt++; $display("FAIL underrun_count got=%0d exp=6", got_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() > base + i) begin
        vec_cnt++; if (got_q[base+i] !== fifo_mem[e0+i]) begin err_cnt++; $display("FAIL underrun_word%0d got=%h exp=%h", i, got_q[base+i], fifo_mem[e0+i]); end
      end
    end
    vec_cnt++; if (o_words_read !== 8'd6) begin err_cnt++; $display("FAIL underrun_words_read got=%0d exp=6", o_words_read); end
  endtask

  task automatic test_zero_len();
    int rb, db, c0;
    u_if.m_ready = 1'b1;
    rb = rd_cnt; db = done_cnt;
    pulse_start(0, c0);
    repeat (4) tick();
    vec_cnt++; if (done_cnt - db != 1) begin err_cnt++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt - db); end
    vec_cnt++; if (done_cyc - c0 < 1 || done_cyc - c0 > 2) begin err_cnt++; $display("FAIL zero_done_cycle got=%0d exp=1..2", done_cyc - c0); end
    vec_cnt++; if (rd_cnt != rb) begin err_cnt++; $display("FAIL zero_reads got=%0d exp=0", rd_cnt - rb); end
    vec_cnt++; if (o_words_read !== 8'd0) begin err_cnt++; $display("FAIL zero_words_read got=%0d exp=0", o_words_read); end
    vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL zero_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_busy_ignore();
    int base, rb, db, c0, c1, e0;
    bit ok;
    e0 = rd_idx;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    u_if.m_ready = 1'b1;
    base = got_q.size(); rb = rd_cnt; db = done_cnt;
    pulse_start(4, c0);
    tick();
    pulse_start(7, c1);
    wait_done(db, 30, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL busy_done_timeout got=0 exp=1"); end
    repeat (6) tick();
    vec_cnt++; if (got_q.size() - base != 4) begin err_cnt++; $display("FAIL busy_count got=%0d exp=4", got_q.size() - base); end
    vec_cnt++; if (rd_cnt - rb != 4) begin err_cnt++; $display("FAIL busy_reads got=%0d exp=4", rd_cnt - rb); end
    vec_cnt++; if (o_words_read !== 8'd4) begin err_cnt++; $display("FAIL busy_words_read got=%0d exp=4", o_words_read); end
    vec_cnt++; if (done_cnt - db != 1) begin err_cnt++; $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt - db); end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i) begin
        vec_cnt++; if (got_q[base+i] !== fifo_mem[e0+i]) begin err_cnt++; $display("FAIL busy_word%0d got=%h exp=%h", i, got_q[base+i], fifo_mem[e0+i]); end
      end
    end
    // Drain the 4 words left in the FIFO model so later tests start clean.
    db = done_cnt;
    pulse_start(4, c0);
    wait_done(db, 30, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL busy_cleanup_timeout got=0 exp=1"); end
    vec_cnt++; if (wr_idx != rd_idx) begin err_cnt++; $display("FAIL busy_cleanup_fifo got=%0d exp=%0d", rd_idx, wr_idx); end
  endtask

  task automatic test_reset_mid();
    int base, db, c0, e0;
    bit ok;
    for (int i = 0; i < 5; i++) push_word(8'($urandom));
    u_if.m_ready = 1'b0;
    pulse_start(5, c0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    vec_cnt++; if (u_if.m_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_m_valid got=%b exp=0", u_if.m_valid); end
    vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    vec_cnt++; if (u_if.fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL rstmid_rd_en got=%b exp=0", u_if.fifo_rd_en); end
    tick();
    rst = 1'b0;
    tick();
    push_word(8'($urandom));
    e0 = rd_idx;
    u_if.m_ready = 1'b1;
    base = got_q.size(); db = done_cnt;
    pulse_start(2, c0);
    wait_done(db, 30, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rstmid_done_timeout got=0 exp=1"); end
    vec_cnt++; if (got_q.size() - base != 2) begin err_cnt++; $display("FAIL rstmid_count got=%0d exp=2", got_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > base + i) begin
        vec_cnt++; if (got_q[base+i] !== fifo_mem[e0+i]) begin err_cnt++; $display("FAIL rstmid_word%0d got=%h exp=%h", i, got_q[base+i], fifo_mem[e0+i]); end
      end
    end
    vec_cnt++; if (o_words_read !== 8'd2) begin err_cnt++; $display("FAIL rstmid_words_read got=%0d exp=2", o_words_read); end
    // Discard whatever is still sitting in the FIFO model.
    rd_idx = wr_idx;
    tick();
  endtask

  task automatic test_random();
    int len, pre, pending, base, rb, db, hb, c0, e0;
    bit ok;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 12);
      pre = $urandom_range(0, len);
      e0  = rd_idx;
      for (int i = 0; i < pre; i++) push_word(8'($urandom));
      pending = len - pre;
      ready_rand = 1'b1;
      base = got_q.size(); rb = rd_cnt; db = done_cnt; hb = hs_err;
      pulse_start(len, c0);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        tick();
        if (pending > 0 && $urandom_range(0, 2) == 0) begin
          push_word(8'($urandom));
          pending--;
        end
        if (done_cnt > db) begin
          ok = 1'b1;
          break;
        end
      end
      ready_rand = 1'b0;
      u_if.m_ready = 1'b1;
      tick();
      vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rand%0d_done_timeout got=0 exp=1", b); end
      vec_cnt++; if (got_q.size() - base != len) begin err_cnt++; $display("FAIL rand%0d_count got=%0d exp=%0d", b, got_q.size() - base, len); end
      for (int i = 0; i < len; i++) begin
        if (got_q.size() > base + i) begin
          vec_cnt++; if (got_q[base+i] !== fifo_mem[e0+i]) begin err_cnt++; $display("FAIL rand%0d_word%0d got=%h exp=%h", b, i, got_q[base+i], fifo_mem[e0+i]); end
        end
      end
      vec_cnt++; if (rd_cnt - rb != len) begin err_cnt++; $display("FAIL rand%0d_reads got=%0d exp=%0d", b, rd_cnt - rb, len); end
      vec_cnt++; if (o_words_read !== LEN_W'(len)) begin err_cnt++; $display("FAIL rand%0d_words_read got=%0d exp=%0d", b, o_words_read, len); end
      vec_cnt++; if (done_cnt - db != 1) begin err_cnt++; $display("FAIL rand%0d_done_pulses got=%0d exp=1", b, done_cnt - db); end
      vec_cnt++; if (hs_err != hb) begin err_cnt++; $display("FAIL rand%0d_handshake got=%0d exp=%0d", b, hs_err, hb); end
    end
  endtask

  initial begin
    u_if.m_ready = 1'b0;
    test_reset();
    test_unstalled();
    test_backpressure();
    test_underrun();
    test_zero_len();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
